// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the simple-dual-port RAM.
package ram_pkg;

    // Legal read latencies
    localparam int unsigned ReadLatComb = 0;
    localparam int unsigned ReadLatReg  = 1;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } clear_state_e;

    // Address width; a 1-bit floor keeps tiny memories well formed
    function automatic int unsigned calc_aw(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Number of byte lanes per word
    function automatic int unsigned calc_nb(input int unsigned word_width,
                                            input int unsigned byte_width);
        return word_width / byte_width;
    endfunction

    function automatic bit latency_legal(input int unsigned lat);
        return (lat == ReadLatComb) || (lat == ReadLatReg);
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every cell once, one per cycle, then idles.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned WORDS          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned AW            = calc_aw(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr,
    output logic          busy
);

    localparam logic [AW-1:0] LastAddr = AW'(WORDS - 1);

    clear_state_e  state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          busy_q;

    // State, sweep counter and registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? StClear : StReady;
            count_q <= '0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == StClear);
        end
    end

    // Next state: one cell per cycle, leave CLEAR on the cycle that writes the last cell
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StClear: begin
                if (count_q == LastAddr) begin
                    state_d = StReady;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StReady;
        endcase
    end

    // Outputs: clear write strobe and address track the current state
    always_comb begin
        clear_we   = (state_q == StClear);
        clear_addr = count_q;
        busy       = busy_q;
    end

endmodule

// File: rtl/ram_dual_port.sv
// Simple-dual-port RAM with byte-lane writes, 0/1-cycle read latency,
// selectable read-during-write ordering and a post-reset clear sweep.
module ram_dual_port
    import ram_pkg::*;
#(
    parameter int unsigned WORDS          = 1024,
    parameter int unsigned WORD_WIDTH     = 8,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          WRITE_FIRST    = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned AW            = calc_aw(WORDS),
    localparam int unsigned NB            = calc_nb(WORD_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         wr_address_i,
    input  logic                  wr_en_i,
    input  logic [NB-1:0]         wr_be_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_address_i,
    input  logic                  rd_en_i,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  busy_o
);

    if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("WORD_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be 0 or 1");
    end

    logic [WORD_WIDTH-1:0] mem [WORDS];

    logic                  clear_we;
    logic [AW-1:0]         clear_addr;
    logic                  busy;

    logic                  wr_in_range, rd_in_range, wr_accept, collision;
    logic [WORD_WIDTH-1:0] wr_old, wr_merged, rd_old, rd_word;

    ram_clear_seq #(
        .WORDS          (WORDS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .busy       (busy)
    );

    assign busy_o      = busy;
    assign wr_in_range = 32'(wr_address_i) < WORDS;
    assign rd_in_range = 32'(rd_address_i) < WORDS;
    assign wr_accept   = ~busy & wr_en_i & wr_in_range;
    assign collision   = wr_accept & rd_en_i & (rd_address_i == wr_address_i);

    // Lane merge of the incoming write onto the addressed word
    always_comb begin
        wr_old    = wr_in_range ? mem[wr_address_i] : '0;
        wr_merged = wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wr_be_i[b]) begin
                wr_merged[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read word: out-of-range reads return zero; write-first forwards the merged word
    always_comb begin
        rd_old  = rd_in_range ? mem[rd_address_i] : '0;
        rd_word = (WRITE_FIRST && collision) ? wr_merged : rd_old;
    end

    // Storage: the clear sweep owns the array while busy, no writes during reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clear_we) begin
                mem[clear_addr] <= '0;
            end else if (wr_accept) begin
                mem[wr_address_i] <= wr_merged;
            end
        end
    end

    if (READ_LATENCY == ReadLatReg) begin : g_rd_reg
        logic [WORD_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read: capture on an accepted read, hold data otherwise
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_en_i & ~busy;
                if (rd_en_i && !busy) begin
                    rd_data_q <= rd_word;
                end
            end
        end

        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end else begin : g_rd_comb
        // Combinational read always sees the pre-write contents
        assign rd_data_o  = busy ? '0 : rd_old;
        assign rd_valid_o = rd_en_i & ~busy;
    end

endmodule

// File: tb/tb_ram_dual_port.sv
// Bench for ram_dual_port: three configurations share one stimulus stream and
// are compared every cycle against an array-based model, plus literal spot checks.
module tb_ram_dual_port;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  wr_addr, rd_addr;
    logic        wr_en, rd_en;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic [31:0] d_a;
    logic [15:0] d_b;
    logic [7:0]  d_c;
    logic        v_a, v_b, v_c, b_a, b_b, b_c;

    int n_pass  = 0;
    int n_total = 0;

    // a: 16x32 registered write-old; b: 10x16 registered write-first; c: 16x8 combinational
    ram_dual_port #(.WORDS(16), .WORD_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1),
                    .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .reset(reset), .wr_address_i(wr_addr), .wr_en_i(wr_en), .wr_be_i(be),
        .wr_data_i(wdata), .rd_address_i(rd_addr), .rd_en_i(rd_en), .rd_data_o(d_a),
        .rd_valid_o(v_a), .busy_o(b_a));

    ram_dual_port #(.WORDS(10), .WORD_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(1),
                    .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .reset(reset), .wr_address_i(wr_addr), .wr_en_i(wr_en), .wr_be_i(be[1:0]),
        .wr_data_i(wdata[15:0]), .rd_address_i(rd_addr), .rd_en_i(rd_en), .rd_data_o(d_b),
        .rd_valid_o(v_b), .busy_o(b_b));

    ram_dual_port #(.WORDS(16), .WORD_WIDTH(8), .BYTE_WIDTH(8), .READ_LATENCY(0),
                    .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) u_c (
        .clk(clk), .reset(reset), .wr_address_i(wr_addr), .wr_en_i(wr_en), .wr_be_i(be[0:0]),
        .wr_data_i(wdata[7:0]), .rd_address_i(rd_addr), .rd_en_i(rd_en), .rd_data_o(d_c),
        .rd_valid_o(v_c), .busy_o(b_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] act_d [NI];
    logic        act_v [NI];
    logic        act_b [NI];

    always_comb begin
        act_d[0] = d_a;
        act_d[1] = {16'h0, d_b};
        act_d[2] = {24'h0, d_c};
        act_v[0] = v_a;
        act_v[1] = v_b;
        act_v[2] = v_c;
        act_b[0] = b_a;
        act_b[1] = b_b;
        act_b[2] = b_c;
    end

    // Per-instance configuration
    function automatic int words_of(input int i);
        return (i == 1) ? 10 : 16;
    endfunction
    function automatic int nb_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction
    function automatic bit wf_of(input int i);
        return i == 1;
    endfunction
    function automatic bit registered_of(input int i);
        return i != 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: contents, remaining clear cycles, last registered read
    logic [31:0] m_mem [NI][16];
    int          m_left [NI];
    int          m_idx  [NI];
    logic [31:0] m_rd   [NI];
    logic        m_val  [NI];
    bit          started = 1'b0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
            m_left[i] = 0;
            m_idx[i]  = 0;
            m_rd[i]   = '0;
            m_val[i]  = 1'b0;
        end
    end

    function automatic logic [31:0] rd_value(input int i);
        return (int'(rd_addr) < words_of(i)) ? m_mem[i][rd_addr] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input int i);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < nb_of(i); b++) begin
            if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

    // Compare outputs against the model, then advance the model over the coming edge
    always @(negedge clk) begin
        logic [31:0] rv;
        logic        busy_e;
        #2;
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                busy_e = m_left[i] > 0;
                chk($sformatf("busy[%0d]", i), {31'h0, act_b[i]}, {31'h0, busy_e});
                if (registered_of(i)) begin
                    chk($sformatf("rd_data[%0d]", i), act_d[i], m_rd[i]);
                    chk($sformatf("rd_valid[%0d]", i), {31'h0, act_v[i]}, {31'h0, m_val[i]});
                end else begin
                    chk($sformatf("rd_data[%0d]", i), act_d[i], busy_e ? 32'h0 : rd_value(i));
                    chk($sformatf("rd_valid[%0d]", i), {31'h0, act_v[i]},
                        {31'h0, rd_en & ~busy_e});
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_left[i] = words_of(i);
                m_idx[i]  = 0;
                m_rd[i]   = '0;
                m_val[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_mem[i][m_idx[i]] = '0;
                m_idx[i]++;
                m_left[i]--;
                m_val[i] = 1'b0;
            end else begin
                rv = rd_value(i);
                if (wr_en && int'(wr_addr) < words_of(i)) begin
                    m_mem[i][wr_addr] = merge(m_mem[i][wr_addr], i);
                end
                if (wf_of(i)) rv = rd_value(i);
                m_val[i] = rd_en;
                if (rd_en) m_rd[i] = rv;
            end
        end
        if (reset) started = 1'b1;
    end

    task automatic cyc(input logic r, input logic we, input int wa, input logic [3:0] wbe,
                       input logic [31:0] wd, input logic re, input int ra);
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        wr_addr = 4'(wa);
        be      = wbe;
        wdata   = wd;
        rd_en   = re;
        rd_addr = 4'(ra);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
    endtask

    // Runs 40 cycles after reset release, writing 0xFF to cell k during the first 16
    task automatic count_busy(input bit write_during);
        int na, nb, nc;
        na = 0;
        nb = 0;
        nc = 0;
        for (int k = 0; k < 40; k++) begin
            if (write_during && k < 16) cyc(1'b0, 1'b1, k, 4'hF, 32'hFFFF_FFFF, 1'b0, 0);
            else idle();
            #3;
            if (b_a) na++;
            if (b_b) nb++;
            if (b_c) nc++;
        end
        chk("busy_cycles_a", 32'(na), 32'd16);
        chk("busy_cycles_b", 32'(nb), 32'd10);
        chk("busy_cycles_c", 32'(nc), 32'd16);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; be = '0; wdata = '0;
        cyc(1'b1, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
        cyc(1'b1, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
        #3;
        chk("reset_rd_data_a", d_a, 32'h0);
        chk("reset_rd_valid_a", {31'h0, v_a}, 32'h0);

        // Sweep length, then every cell reads zero with one valid per request
        count_busy(1'b0);
        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, a);
            #3;
            if (a > 0) begin
                chk("swept_cell_a", d_a, 32'h0);
                chk("swept_valid_a", {31'h0, v_a}, 32'h1);
            end
        end
        idle();

        // Byte-lane merge
        cyc(1'b0, 1'b1, 3, 4'hF, 32'hAABB_CCDD, 1'b0, 0);
        cyc(1'b0, 1'b1, 3, 4'h5, 32'h1122_3344, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        #3 chk("merge_c_comb", {24'h0, d_c}, 32'h44);
        idle();
        #3;
        chk("merge_a", d_a, 32'hAA22_CC44);
        chk("merge_b", {16'h0, d_b}, 32'hCC44);

        // Collision on cell 5
        cyc(1'b0, 1'b1, 5, 4'h1, 32'h0000_005A, 1'b1, 5);
        #3 chk("collision_c_old", {24'h0, d_c}, 32'h0);
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
        #3;
        chk("collision_a_old", d_a, 32'h0);
        chk("collision_b_new", {16'h0, d_b}, 32'h5A);
        chk("after_write_c", {24'h0, d_c}, 32'h5A);

        // Combinational read sees last cycle's write
        cyc(1'b0, 1'b1, 2, 4'hF, 32'h0000_003C, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 2);
        #3;
        chk("lat0_data_c", {24'h0, d_c}, 32'h3C);
        chk("lat0_valid_c", {31'h0, v_c}, 32'h1);
        idle();
        #3 chk("lat0_novalid_c", {31'h0, v_c}, 32'h0);

        // Out-of-range on the 10-word instance
        cyc(1'b0, 1'b1, 12, 4'hF, 32'h0000_0077, 1'b0, 0);
        cyc(1'b0, 1'b1, 9, 4'hF, 32'h0000_0099, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 12);
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 9);
        #3;
        chk("oor_read_b", {16'h0, d_b}, 32'h0);
        chk("oor_valid_b", {31'h0, v_b}, 32'h1);
        idle();
        #3 chk("last_cell_b", {16'h0, d_b}, 32'h99);

        // Reset re-asserted mid-sweep; writes issued while busy are ignored
        cyc(1'b0, 1'b1, 12, 4'hF, 32'h0000_00FF, 1'b0, 0);
        cyc(1'b1, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
        for (int k = 0; k < 7; k++) idle();
        cyc(1'b1, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
        count_busy(1'b1);
        cyc(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 12);
        #3 chk("restart_c12", {24'h0, d_c}, 32'h0);
        idle();
        #3 chk("restart_a12", d_a, 32'h0);

        // Random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 399) == 0), 1'($urandom), int'($urandom_range(0, 15)),
                4'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 15)));
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
